// File: rtl/dcache_mem_ctl_if.sv
// Cache-side request and nibble-stream signals plus the QSPI-style PSRAM pins of dcache_mem_ctl.
// The controller takes the slave modport; the cache/memory side takes master.
interface dcache_mem_ctl_if #(
    parameter int PA          = 22,
    parameter int LINE_LENGTH = 4
);
    localparam int TW = PA - $clog2(LINE_LENGTH);

    logic          req;
    logic          push;
    logic          pull;
    logic [TW-1:0] tag;
    logic [3:0]    dwrite;
    logic [3:0]    dread;
    logic          wstrobe_d;
    logic          rstrobe_d;
    logic          busy;
    logic          done;
    logic          mem_cs_n;
    logic [3:0]    mem_dout;
    logic          mem_oe;
    logic [3:0]    mem_din;

    modport master (
        output req, push, pull, tag, dwrite, mem_din,
        input  dread, wstrobe_d, rstrobe_d, busy, done, mem_cs_n, mem_dout, mem_oe
    );

    modport slave (
        input  req, push, pull, tag, dwrite, mem_din,
        output dread, wstrobe_d, rstrobe_d, busy, done, mem_cs_n, mem_dout, mem_oe
    );
endinterface

// File: rtl/dcache_mem_ctl.sv
// Line fill / writeback engine: runs one nibble-serial PSRAM transaction per cache miss.
// All outputs are registered from the next-state decode so they line up with the state they belong to.
module dcache_mem_ctl #(
    parameter int         PA          = 22,
    parameter int         LINE_LENGTH = 4,
    parameter int         WAIT_CYCLES = 6,
    parameter logic [7:0] CMD_READ    = 8'hEB,
    parameter logic [7:0] CMD_WRITE   = 8'h38
) (
    input logic             clk,
    input logic             reset,
    dcache_mem_ctl_if.slave bus
);
    localparam int OFFS = $clog2(LINE_LENGTH);
    localparam int TW   = PA - OFFS;
    localparam int NIB  = 2 * LINE_LENGTH;
    localparam int CMAX = (NIB > WAIT_CYCLES) ? ((NIB > 6) ? NIB : 6)
                                              : ((WAIT_CYCLES > 6) ? WAIT_CYCLES : 6);
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, GAP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          write_reg, write_next;
    logic [TW-1:0] tag_reg, tag_next;
    logic          mem_cs_n_reg, mem_cs_n_next;
    logic          mem_oe_reg, mem_oe_next;
    logic [3:0]    mem_dout_reg, mem_dout_next;
    logic          wstrobe_reg, wstrobe_next;
    logic          rstrobe_reg, rstrobe_next;
    logic [3:0]    dread_reg, dread_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic [7:0]    cmd_next;
    logic [23:0]   addr_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            write_reg    <= 1'b0;
            tag_reg      <= '0;
            mem_cs_n_reg <= 1'b1;
            mem_oe_reg   <= 1'b0;
            mem_dout_reg <= 4'h0;
            wstrobe_reg  <= 1'b0;
            rstrobe_reg  <= 1'b0;
            dread_reg    <= 4'h0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            write_reg    <= write_next;
            tag_reg      <= tag_next;
            mem_cs_n_reg <= mem_cs_n_next;
            mem_oe_reg   <= mem_oe_next;
            mem_dout_reg <= mem_dout_next;
            wstrobe_reg  <= wstrobe_next;
            rstrobe_reg  <= rstrobe_next;
            dread_reg    <= dread_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        write_next = write_reg;
        tag_next   = tag_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus.req && (bus.push || bus.pull)) begin
                    state_next = CMD;
                    write_next = bus.push;   // push wins when both are raised
                    tag_next   = bus.tag;
                end
            end
            CMD: if (cnt_reg == CW'(1)) begin
                state_next = ADDR;
                cnt_next   = '0;
            end
            ADDR: if (cnt_reg == CW'(5)) begin
                state_next = write_reg ? DATA : WAIT;
                cnt_next   = '0;
            end
            WAIT: if (cnt_reg == CW'(WAIT_CYCLES - 1)) begin
                state_next = DATA;
                cnt_next   = '0;
            end
            DATA: if (cnt_reg == CW'(NIB - 1)) begin
                state_next = GAP;
                cnt_next   = '0;
            end
            GAP: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        cmd_next  = write_next ? CMD_WRITE : CMD_READ;
        addr_next = 24'({tag_next, {OFFS{1'b0}}});

        mem_cs_n_next = !(state_next inside {CMD, ADDR, WAIT, DATA});
        mem_oe_next   = (state_next == CMD) || (state_next == ADDR) ||
                        (state_next == DATA && write_next);
        busy_next     = (state_next != IDLE);
        done_next     = (state_next == GAP);

        mem_dout_next = 4'h0;
        case (state_next)
            CMD:  mem_dout_next = (cnt_next == '0) ? cmd_next[7:4] : cmd_next[3:0];
            ADDR: begin
                case (cnt_next)
                    CW'(0):  mem_dout_next = addr_next[23:20];
                    CW'(1):  mem_dout_next = addr_next[19:16];
                    CW'(2):  mem_dout_next = addr_next[15:12];
                    CW'(3):  mem_dout_next = addr_next[11:8];
                    CW'(4):  mem_dout_next = addr_next[7:4];
                    default: mem_dout_next = addr_next[3:0];
                endcase
            end
            DATA: mem_dout_next = write_next ? bus.dwrite : 4'h0;
            default: mem_dout_next = 4'h0;
        endcase

        // Consume strobe leads the data phase by one cycle so mem_dout is a registered copy of dwrite.
        rstrobe_next = write_next &&
                       ((state_next == ADDR && cnt_next == CW'(5)) ||
                        (state_next == DATA && cnt_next != CW'(NIB - 1)));
        wstrobe_next = !write_reg && (state_reg == DATA);
        dread_next   = wstrobe_next ? bus.mem_din : 4'h0;
    end

    assign bus.mem_cs_n  = mem_cs_n_reg;
    assign bus.mem_oe    = mem_oe_reg;
    assign bus.mem_dout  = mem_dout_reg;
    assign bus.wstrobe_d = wstrobe_reg;
    assign bus.rstrobe_d = rstrobe_reg;
    assign bus.dread     = dread_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
endmodule
